hs_master_arbiter: RTL

Master-side controller that shares one 4-phase req/ack byte slave (`slave_fsm`-style responder) among `N_REQ` local sources. Round-robin arbitration selects a pending source, the block drives `req`/`data_out` through a full four-phase handshake, then returns a one-cycle completion pulse to the winner. An ack timeout stops a dead slave from hanging the sources. It sits between the producer blocks and the slave link.

---
 rtl/hs_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/hs_master_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared types and constants for the four-phase handshake master arbiter.
package hs_pkg;

    // Handshake master FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_REQ_LO = 2'd2,
        ST_DONE   = 2'd3
    } hs_state_t;

    localparam int HS_DW      = 8;
    localparam int XFER_CNT_W = 16;

    // Index reached by stepping 'off' positions past 'base' on a ring of 'n' entries
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first requesting source after rr_ptr wins.
module rr_arbiter
    import hs_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IW-1:0]    rr_ptr,
    output logic             any_req,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IW-1:0]    grant_idx
);

    // Walk the ring starting just past the last winner; the nearest requester is taken
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!any_req && req_vec[IW'(wrap_idx(int'(rr_ptr), off, N_REQ))]) begin
                any_req   = 1'b1;
                grant_idx = IW'(wrap_idx(int'(rr_ptr), off, N_REQ));
            end
        end
        if (any_req) begin
            grant_oh = N_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/hs_master_arbiter.sv
// Shares one four-phase req/ack byte slave among N_REQ sources with round-robin
// arbitration, an ack timeout in REQ_HI and a wrapping success counter.
module hs_master_arbiter
    import hs_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DW      = HS_DW,
    parameter  int TIMEOUT = 15,
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      src_valid,
    input  logic [N_REQ*DW-1:0]   src_data,
    output logic [N_REQ-1:0]      src_done,
    output logic                  req,
    output logic [DW-1:0]         data_out,
    input  logic                  ack,
    output logic                  busy,
    output logic [IW-1:0]         grant_id,
    output logic                  timeout_err,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    // Wide enough to hold TIMEOUT-1, the last value counted before giving up
    localparam int TW = $clog2(TIMEOUT + 1);

    hs_state_t             state;
    logic [IW-1:0]         rr_ptr;
    logic [TW-1:0]         tmo_cnt;
    logic                  err_flag;
    logic [N_REQ-1:0]      grant_oh_q;
    logic [XFER_CNT_W-1:0] xfer_cnt_q;

    logic                  arb_any;
    logic [N_REQ-1:0]      arb_oh;
    logic [IW-1:0]         arb_idx;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_vec   (src_valid),
        .rr_ptr    (rr_ptr),
        .any_req   (arb_any),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    assign xfer_count = xfer_cnt_q;

    // Handshake FSM; every output is registered so the slave sees glitch-free req/data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            req         <= 1'b0;
            data_out    <= '0;
            src_done    <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            grant_oh_q  <= '0;
            timeout_err <= 1'b0;
            xfer_cnt_q  <= '0;
            rr_ptr      <= IW'(N_REQ - 1);
            tmo_cnt     <= '0;
            err_flag    <= 1'b0;
        end else begin
            // Completion and error are single-cycle pulses
            src_done    <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        // Byte is captured once here; later source changes are ignored
                        grant_id   <= arb_idx;
                        grant_oh_q <= arb_oh;
                        data_out   <= src_data[arb_idx*DW +: DW];
                        req        <= 1'b1;
                        busy       <= 1'b1;
                        tmo_cnt    <= '0;
                        err_flag   <= 1'b0;
                        state      <= ST_REQ_HI;
                    end
                end
                ST_REQ_HI: begin
                    if (ack) begin
                        // An ack on the final allowed cycle still counts as success
                        req   <= 1'b0;
                        state <= ST_REQ_LO;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        req      <= 1'b0;
                        err_flag <= 1'b1;
                        state    <= ST_REQ_LO;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_REQ_LO: begin
                    // Wait for the slave to release ack; no timeout on this phase
                    if (!ack) begin
                        src_done    <= grant_oh_q;
                        timeout_err <= err_flag;
                        if (!err_flag) begin
                            xfer_cnt_q <= xfer_cnt_q + 1'b1;
                        end
                        rr_ptr   <= grant_id;
                        err_flag <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
